delta_reconstruct: RTL

DELTA_RECONSTRUCT -- requirements
Module: delta_reconstruct

---
 rtl/delta_reconstruct_pkg.sv | 15 +
 rtl/delta_apply.sv | 37 +++
 rtl/delta_reconstruct.sv | 80 ++++++++
 3 files changed

// File: rtl/delta_reconstruct_pkg.sv
// Shared types and constants for the delta reconstruction block.
package delta_reconstruct_pkg;

    // IDLE: no base loaded, RUN: accumulator valid and output empty,
    // HOLD: output register occupied and waiting for the consumer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/delta_apply.sv
// Combinational accumulator update: acc +/- mag at WIDTH+1 bits, then
// clamp or wrap on carry/borrow and report it on clip.
module delta_apply #(
    parameter int WIDTH    = 16,
    parameter int SATURATE = 1
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mag,
    input  logic             dir,
    output logic [WIDTH-1:0] result,
    output logic             clip
);
    import delta_reconstruct_pkg::*;

    logic [WIDTH:0] ext;

    // The extra top bit is the carry for an add and the borrow for a subtract,
    // so one bit tells both directions that the result left the range.
    function automatic logic [WIDTH-1:0] limit(input logic [WIDTH:0] raw, input logic down);
        if (SATURATE == 0 || !raw[WIDTH]) begin
            return raw[WIDTH-1:0];
        end
        return down ? '0 : '1;
    endfunction

    // Extended add/subtract followed by the range limiter.
    always_comb begin
        if (dir == DIR_DOWN) begin
            ext = {1'b0, acc} - {1'b0, mag};
        end else begin
            ext = {1'b0, acc} + {1'b0, mag};
        end
        result = limit(ext, dir == DIR_DOWN);
        clip   = ext[WIDTH];
    end

endmodule

// File: rtl/delta_reconstruct.sv
// Rebuilds an absolute sample stream from (magnitude, direction) difference
// tokens, starting from a loaded base value. One-entry output register with
// full-throughput handshakes on both sides.
module delta_reconstruct #(
    parameter int WIDTH    = 16,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] base,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mag,
    input  logic             dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] value,
    output logic             clip,
    output logic [15:0]      count
);
    import delta_reconstruct_pkg::*;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] next_acc;
    logic             step_clip;
    logic             accept;
    logic             drain;

    delta_apply #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_apply (
        .acc    (acc),
        .mag    (mag),
        .dir    (dir),
        .result (next_acc),
        .clip   (step_clip)
    );

    // A token may enter whenever the output slot is empty or being emptied
    // this cycle; load always wins so a concurrent token is dropped.
    assign in_ready = !load && ((state == RUN) || (state == HOLD && out_ready));
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // Control FSM with the accumulator and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            value     <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
            count     <= '0;
        end else if (load) begin
            state     <= RUN;
            acc       <= base;
            out_valid <= 1'b0;
            clip      <= 1'b0;
            count     <= '0;
        end else begin
            if (drain) begin
                count <= count + 16'd1;
            end
            if (accept) begin
                acc       <= next_acc;
                value     <= next_acc;
                out_valid <= 1'b1;
                clip      <= clip | step_clip;
                state     <= HOLD;
            end else if (drain) begin
                out_valid <= 1'b0;
                state     <= RUN;
            end
        end
    end

endmodule
